// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer: per-port ingress buffer; validates length (and FCS when RX_CRC_CHECK_EN is defined), commits good frames to byte + descriptor FIFOs.
// Latency: descriptor visible the cycle after the first rx_dv=0 cycle; sfifo_dout/ptr_sfifo_dout registered, valid one cycle after the strobe.
// Backpressure: none toward rx; frames that do not fit (data or descriptor space) are dropped by rewinding the speculative write pointer.
module rx_frame_buffer #(
   parameter int         DATA_AW  = 12,
   parameter int         PTR_AW   = 5,
   parameter logic [3:0] PORT_MAP = 4'b0001,
   parameter int         MIN_LEN  = 64,
   parameter int         MAX_LEN  = 1522
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_dv,
   input  logic [7:0]  rx_data,
   input  logic        sfifo_rd,
   output logic [7:0]  sfifo_dout,
   input  logic        ptr_sfifo_rd,
   output logic [15:0] ptr_sfifo_dout,
   output logic        ptr_sfifo_empty,
   output logic [15:0] drop_cnt,
   output logic [15:0] frame_cnt
);

   typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

   localparam logic [DATA_AW:0] PTR_ONE  = {{DATA_AW{1'b0}}, 1'b1};
   localparam logic [DATA_AW:0] FULL_GAP = {1'b1, {DATA_AW{1'b0}}};
   localparam logic [PTR_AW:0]  DPTR_ONE = {{PTR_AW{1'b0}}, 1'b1};
   localparam logic [10:0]      LEN_MIN  = 11'(MIN_LEN);
   localparam logic [10:0]      LEN_MAX  = 11'(MAX_LEN);
   localparam logic [10:0]      LEN_SAT  = 11'h7FF;

   state_t           state;
   logic [DATA_AW:0] wr_ptr;     // speculative: advances with every stored byte
   logic [DATA_AW:0] cmt_ptr;    // end of the last committed frame
   logic [DATA_AW:0] rd_ptr;
   logic [10:0]      len;
   logic [7:0]       ram [2**DATA_AW];

   logic [15:0]      desc_mem [2**PTR_AW];
   logic [PTR_AW:0]  dwr_ptr;
   logic [PTR_AW:0]  drd_ptr;

   logic             data_full;
   logic             desc_full;
   logic             len_ok;
   logic             crc_ok;
   logic             eof;
   logic             commit;
   logic             wr_en;

   assign ptr_sfifo_empty = (dwr_ptr == drd_ptr);
   assign desc_full       = (dwr_ptr[PTR_AW] != drd_ptr[PTR_AW]) &&
                            (dwr_ptr[PTR_AW-1:0] == drd_ptr[PTR_AW-1:0]);

   // Frame verdict; free space is judged against this cycle's rd_ptr, so a same-cycle read never makes room.
   always_comb begin
      data_full = ((wr_ptr - rd_ptr) == FULL_GAP);
      len_ok    = (len >= LEN_MIN) && (len <= LEN_MAX);
      eof       = (state == RECV) && !rx_dv;
      commit    = eof && len_ok && crc_ok && !desc_full;
      wr_en     = rx_dv && !data_full && (state != DROP);
   end

`ifdef RX_CRC_CHECK_EN
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

   logic [31:0] crc;
   logic [31:0] crc_msb_first;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // Running CRC over every stored byte, FCS included; the first byte of a frame reseeds it.
   always_ff @(posedge clk) begin
      if (rst)
         crc <= '1;
      else if (wr_en)
         crc <= crc_byte((state == IDLE) ? 32'hFFFFFFFF : crc, rx_data);
   end

   // The register shifts LSB-first; the residue constant is expressed MSB-first.
   always_comb begin
      crc_msb_first = '0;
      for (int i = 0; i < 32; i++)
         crc_msb_first[i] = crc[31-i];
      crc_ok = (crc_msb_first == CRC_RESIDUE);
   end
`else
   assign crc_ok = 1'b1;
`endif

   // Write-side FSM: speculative store, commit or rewind at end of frame, frame/drop counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         cmt_ptr   <= '0;
         len       <= '0;
         drop_cnt  <= '0;
         frame_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (rx_dv) begin
                  // A completely full buffer cannot take even the first byte.
                  if (data_full) begin
                     state <= DROP;
                  end else begin
                     wr_ptr <= wr_ptr + PTR_ONE;
                     len    <= 11'd1;
                     state  <= RECV;
                  end
               end
            end
            RECV: begin
               if (rx_dv) begin
                  if (data_full) begin
                     wr_ptr <= cmt_ptr;
                     state  <= DROP;
                  end else begin
                     wr_ptr <= wr_ptr + PTR_ONE;
                     if (len != LEN_SAT)
                        len <= len + 11'd1;
                  end
               end else begin
                  if (commit) begin
                     cmt_ptr   <= wr_ptr;
                     frame_cnt <= frame_cnt + 16'd1;
                  end else begin
                     wr_ptr <= cmt_ptr;
                     if (drop_cnt != 16'hFFFF)
                        drop_cnt <= drop_cnt + 16'd1;
                  end
                  state <= IDLE;
               end
            end
            DROP: begin
               if (!rx_dv) begin
                  if (drop_cnt != 16'hFFFF)
                     drop_cnt <= drop_cnt + 16'd1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Data RAM write port; only the speculative region beyond cmt_ptr is ever written.
   always_ff @(posedge clk) begin
      if (wr_en)
         ram[wr_ptr[DATA_AW-1:0]] <= rx_data;
   end

   // Data read port: only committed bytes are visible; an empty read holds pointer and output.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr     <= '0;
         sfifo_dout <= '0;
      end else if (sfifo_rd && (rd_ptr != cmt_ptr)) begin
         sfifo_dout <= ram[rd_ptr[DATA_AW-1:0]];
         rd_ptr     <= rd_ptr + PTR_ONE;
      end
   end

   // Descriptor storage, written at the end-of-frame edge of a good frame.
   always_ff @(posedge clk) begin
      if (commit)
         desc_mem[dwr_ptr[PTR_AW-1:0]] <= {1'b0, PORT_MAP, len};
   end

   // Descriptor pointers and registered pop data; a pop while full does not free the same-cycle slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         dwr_ptr        <= '0;
         drd_ptr        <= '0;
         ptr_sfifo_dout <= '0;
      end else begin
         if (commit)
            dwr_ptr <= dwr_ptr + DPTR_ONE;
         if (ptr_sfifo_rd && !ptr_sfifo_empty) begin
            ptr_sfifo_dout <= desc_mem[drd_ptr[PTR_AW-1:0]];
            drd_ptr        <= drd_ptr + DPTR_ONE;
         end
      end
   end

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Testbench for rx_frame_buffer: table-driven boundary frames, hand-written multi-cycle corner cases,
// and randomized frames checked against a frame-level reference model (queues of committed bytes/descriptors).
module tb_rx_frame_buffer;

   localparam int         DEPTH      = 4096;
   localparam int         DESC_DEPTH = 32;
   localparam int         MIN_LEN    = 64;
   localparam int         MAX_LEN    = 1522;
   localparam logic [3:0] PORT_MAP   = 4'b0001;
`ifdef RX_CRC_CHECK_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_dv;
   logic [7:0]  rx_data;
   logic        sfifo_rd;
   logic [7:0]  sfifo_dout;
   logic        ptr_sfifo_rd;
   logic [15:0] ptr_sfifo_dout;
   logic        ptr_sfifo_empty;
   logic [15:0] drop_cnt;
   logic [15:0] frame_cnt;

   int checks = 0;
   int errors = 0;

   logic [7:0]  frm[$];
   logic [7:0]  data_q[$];
   logic [15:0] desc_q[$];
   logic [15:0] exp_drop;
   logic [15:0] exp_frame;
   logic [7:0]  last_rd;

   typedef struct {
      int          len;
      bit          corrupt;
      bit          good;
      logic [15:0] desc;
   } vec_t;
   vec_t vecs[6];

   rx_frame_buffer dut (
      .clk            (clk),
      .rst            (rst),
      .rx_dv          (rx_dv),
      .rx_data        (rx_data),
      .sfifo_rd       (sfifo_rd),
      .sfifo_dout     (sfifo_dout),
      .ptr_sfifo_rd   (ptr_sfifo_rd),
      .ptr_sfifo_dout (ptr_sfifo_dout),
      .ptr_sfifo_empty(ptr_sfifo_empty),
      .drop_cnt       (drop_cnt),
      .frame_cnt      (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Standard Ethernet FCS over the first cnt bytes.
   function automatic logic [31:0] fcs32(input logic [7:0] q[$], input int cnt);
      logic [31:0] c = 32'hFFFFFFFF;
      for (int i = 0; i < cnt; i++) begin
         c = c ^ {24'h0, q[i]};
         for (int b = 0; b < 8; b++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic build_frame(input int n, input bit corrupt);
      logic [31:0] f;
      frm.delete();
      for (int i = 0; i < n - 4; i++)
         frm.push_back(8'($urandom));
      f = fcs32(frm, n - 4);
      for (int i = 0; i < 4; i++)
         frm.push_back(f[8*i +: 8]);
      if (corrupt)
         frm[n-1] = frm[n-1] ^ 8'hA5;
   endtask

   // Frame-level reference: committed iff it fits beside the unread committed bytes,
   // its length is in range, its FCS matches, and a descriptor slot is free.
   task automatic model_frame();
      int n;
      bit fits, fcs_ok, good;
      n      = frm.size();
      fits   = (data_q.size() + n) <= DEPTH;
      fcs_ok = !CRC_EN || (fcs32(frm, n - 4) == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]});
      good   = fits && (n >= MIN_LEN) && (n <= MAX_LEN) && fcs_ok && (desc_q.size() < DESC_DEPTH);
      if (good) begin
         foreach (frm[i]) data_q.push_back(frm[i]);
         desc_q.push_back({1'b0, PORT_MAP, 11'(n)});
         exp_frame = exp_frame + 16'd1;
      end else if (exp_drop != 16'hFFFF) begin
         exp_drop = exp_drop + 16'd1;
      end
   endtask

   task automatic send_frame(input bit pop_eof);
      foreach (frm[i]) begin
         rx_dv   = 1'b1;
         rx_data = frm[i];
         tick();
      end
      rx_dv   = 1'b0;
      rx_data = 8'h00;
      check("commit_not_early", ptr_sfifo_empty, desc_q.size() == 0);
      ptr_sfifo_rd = pop_eof;
      tick();
      ptr_sfifo_rd = 1'b0;
      if (!pop_eof) begin
         model_frame();
         check("frame_cnt", frame_cnt, exp_frame);
         check("drop_cnt", drop_cnt, exp_drop);
      end
   endtask

   task automatic pop_one_desc();
      logic [15:0] e;
      e = desc_q.pop_front();
      ptr_sfifo_rd = 1'b1;
      tick();
      ptr_sfifo_rd = 1'b0;
      check("desc", ptr_sfifo_dout, e);
   endtask

   task automatic read_bytes(input int n);
      int mism = 0;
      logic [7:0] e;
      for (int i = 0; i < n; i++) begin
         e = data_q.pop_front();
         sfifo_rd = 1'b1;
         tick();
         if (sfifo_dout !== e) mism++;
         last_rd = e;
      end
      sfifo_rd = 1'b0;
      check("data_bytes_mismatched", mism, 0);
   endtask

   task automatic drain_all();
      while (desc_q.size() > 0) pop_one_desc();
      if (data_q.size() > 0) read_bytes(data_q.size());
      check("drained_desc_empty", ptr_sfifo_empty, 1);
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      rx_dv        = 1'b0;
      rx_data      = 8'h00;
      sfifo_rd     = 1'b0;
      ptr_sfifo_rd = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      data_q.delete();
      desc_q.delete();
      exp_drop  = '0;
      exp_frame = '0;
   endtask

   initial begin
      logic [15:0] t_drop, t_frame, e16;

      vecs[0] = '{64,   1'b0, 1'b1,    16'h0840};
      vecs[1] = '{64,   1'b1, !CRC_EN, 16'h0840};
      vecs[2] = '{63,   1'b0, 1'b0,    16'h0000};
      vecs[3] = '{1523, 1'b0, 1'b0,    16'h0000};
      vecs[4] = '{1522, 1'b0, 1'b1,    16'h0DF2};
      vecs[5] = '{65,   1'b0, 1'b1,    16'h0841};

      // Reset values
      do_reset();
      check("rst_sfifo_dout", sfifo_dout, 0);
      check("rst_ptr_sfifo_dout", ptr_sfifo_dout, 0);
      check("rst_ptr_sfifo_empty", ptr_sfifo_empty, 1);
      check("rst_drop_cnt", drop_cnt, 0);
      check("rst_frame_cnt", frame_cnt, 0);

      // Reads while empty are ignored
      sfifo_rd     = 1'b1;
      ptr_sfifo_rd = 1'b1;
      tick();
      sfifo_rd     = 1'b0;
      ptr_sfifo_rd = 1'b0;
      check("empty_rd_sfifo_dout", sfifo_dout, 0);
      check("empty_rd_ptr_dout", ptr_sfifo_dout, 0);
      check("empty_rd_still_empty", ptr_sfifo_empty, 1);

      // Table-driven boundary frames
      t_drop  = '0;
      t_frame = '0;
      for (int i = 0; i < 6; i++) begin
         build_frame(vecs[i].len, vecs[i].corrupt);
         send_frame(1'b0);
         if (vecs[i].good) t_frame = t_frame + 16'd1;
         else              t_drop  = t_drop + 16'd1;
         check("tbl_empty", ptr_sfifo_empty, !vecs[i].good);
         check("tbl_frame_cnt", frame_cnt, t_frame);
         check("tbl_drop_cnt", drop_cnt, t_drop);
         if (vecs[i].good) begin
            e16 = desc_q.pop_front();
            ptr_sfifo_rd = 1'b1;
            tick();
            ptr_sfifo_rd = 1'b0;
            check("tbl_desc", ptr_sfifo_dout, vecs[i].desc);
            read_bytes(vecs[i].len);
         end
      end

      // Data read with nothing committed holds the last byte
      sfifo_rd = 1'b1;
      tick();
      sfifo_rd = 1'b0;
      check("rd_empty_hold", sfifo_dout, last_rd);

      // Back-to-back 1518-byte frames, no reads: third overflows
      for (int i = 0; i < 3; i++) begin
         build_frame(1518, 1'b0);
         send_frame(1'b0);
      end
      check("ovf_desc_count", desc_q.size(), 2);
      drain_all();

      // Descriptor FIFO full: 33rd frame dropped
      for (int i = 0; i < 33; i++) begin
         build_frame(64, 1'b0);
         send_frame(1'b0);
      end
      check("full_desc_count", desc_q.size(), DESC_DEPTH);
      // A pop on the end-of-frame cycle does not make room for that frame
      build_frame(64, 1'b0);
      send_frame(1'b1);
      e16 = desc_q.pop_front();
      if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
      check("pop_at_eof_desc", ptr_sfifo_dout, e16);
      check("pop_at_eof_drop_cnt", drop_cnt, exp_drop);
      check("pop_at_eof_frame_cnt", frame_cnt, exp_frame);
      read_bytes(64);
      // Now one slot is free
      build_frame(64, 1'b0);
      send_frame(1'b0);
      check("after_pop_desc_count", desc_q.size(), DESC_DEPTH);
      drain_all();

      // Randomized frames with interleaved partial reads
      for (int it = 0; it < 30; it++) begin
         int n, k, r, lim;
         bit bad;
         r = $urandom_range(0, 9);
         if (r < 6)      n = $urandom_range(60, 200);
         else if (r < 9) n = $urandom_range(1500, 1530);
         else            n = $urandom_range(20, 70);
         bad = ($urandom_range(0, 4) == 0);
         build_frame(n, bad);
         send_frame(1'b0);
         if (desc_q.size() > 0 && $urandom_range(0, 1) == 1) pop_one_desc();
         lim = (data_q.size() > 800) ? 800 : data_q.size();
         k   = $urandom_range(0, lim);
         if (k > 0) read_bytes(k);
         check("rnd_desc_empty", ptr_sfifo_empty, desc_q.size() == 0);
      end
      drain_all();

      // Reset mid-frame with committed data pending
      build_frame(64, 1'b0);
      send_frame(1'b0);
      build_frame(64, 1'b0);
      for (int i = 0; i < 30; i++) begin
         rx_dv   = 1'b1;
         rx_data = frm[i];
         tick();
      end
      rst   = 1'b1;
      rx_dv = 1'b0;
      tick();
      rst = 1'b0;
      data_q.delete();
      desc_q.delete();
      exp_drop  = '0;
      exp_frame = '0;
      check("midrst_empty", ptr_sfifo_empty, 1);
      check("midrst_frame_cnt", frame_cnt, 0);
      check("midrst_drop_cnt", drop_cnt, 0);
      check("midrst_sfifo_dout", sfifo_dout, 0);
      build_frame(64, 1'b0);
      send_frame(1'b0);
      check("postrst_desc_count", desc_q.size(), 1);
      check("postrst_frame_cnt", frame_cnt, 1);
      check("postrst_drop_cnt", drop_cnt, 0);
      drain_all();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
